sap1_controller: RTL and testbench
==================================

Name: sap1_controller

Overview:
Controller-sequencer for the 8-bit SAP-1 datapath. A 6-state one-hot ring counter (T1..T6) steps through fetch and execute. Each state, combined with the 4-bit opcode from the instruction register, is decoded into active-high load/enable strobes for the PC, MAR, RAM, IR, accumulator, ALU, B register and output register. The block also provides run/single-step control, halt handling and a retired-instruction counter.

Parameters:
OP_LDA, 4'h0, opcode: load accumulator from memory
OP_ADD, 4'h1, opcode: A <= A + mem
OP_SUB, 4'h2, opcode: A <= A - mem
OP_OUT, 4'hE, opcode: output register <= A
OP_HLT, 4'hF, opcode: stop sequencing

Ports:
i_clk  in  1  system clock; all state changes on rising edge
i_reset  in  1  asynchronous, active-high reset
i_debug  in  1  enables $display trace of state transitions and halt
i_opcode  in  4  IR upper nibble; valid from T4 onward
i_step_mode  in  1  1 = single-step, 0 = free run
i_step  in  1  step request level; rising edge advances one T-state in step mode
o_t_state  out  6  one-hot ring state, bit0 = T1 .. bit5 = T6
o_pc_inc  out  1  PC increment (Cp)
o_pc_out  out  1  PC drives bus (Ep)
o_mar_load  out  1  MAR loads from bus (Lm)
o_ram_out  out  1  RAM drives bus (CE)
o_ir_load  out  1  IR loads from bus (Li)
o_ir_out  out  1  IR low nibble drives bus (Ei)
o_a_load  out  1  accumulator loads (La)
o_a_out  out  1  accumulator drives bus (Ea)
o_b_load  out  1  B register loads (Lb)
o_alu_sub  out  1  ALU subtract select (Su)
o_alu_out  out  1  ALU drives bus (Eu)
o_out_load  out  1  output register loads (Lo)
o_halted  out  1  HLT executed
o_instr_count  out  8  retired-instruction count

Behaviour:
- Reset (async, any time including mid-instruction):
  - ring = T1 (6'b000001), o_halted = 0, o_instr_count = 0, step edge register = 0.
  - All strobe outputs are forced 0 while i_reset is high.
  - The first cycle after deassertion is T1.
- Advance enable (adv):
  - Run mode: adv = 1 every cycle.
  - Step mode: adv = i_step & ~step_q, where step_q is i_step registered each clock.
  - A held-high step advances exactly once. Mode changes take effect on the next clock.
- Ring: when adv = 1 and not halted, T(n) -> T(n+1) and T6 -> T1. Otherwise it holds.
- Strobe gating: every strobe = decode(state, opcode) & adv & ~o_halted. This keeps step mode idempotent: no repeated Cp or loads while waiting.
- Decode (unlisted = 0):
  - T1: pc_out, mar_load
  - T2: pc_inc
  - T3: ram_out, ir_load
  - LDA: T4 ir_out, mar_load; T5 ram_out, a_load; T6 none
  - ADD: T4 ir_out, mar_load; T5 ram_out, b_load; T6 alu_out, a_load
  - SUB: as ADD, plus alu_sub in T6 (alu_sub also 1 in T5 so the ALU settles)
  - OUT: T4 a_out, out_load; T5/T6 none
  - HLT: T4 sets o_halted on the adv edge
  - Other opcodes: NOP, T4-T6 none
- Halt:
  - o_halted rises on the clock edge ending T4 of HLT. The ring stays at T4 and all strobes are 0.
  - Only reset clears halt. HLT is not counted as retired.
- Instruction counter: increments on each T6 -> T1 transition; 8-bit wrap, 255 -> 0.
- Bus exclusivity: at most one of pc_out, ram_out, ir_out, a_out, alu_out is 1 in any cycle.
- Latency: one instruction = 6 advancing clocks. In run mode, the opcode is sampled combinationally during T4-T6.
- Debug: when i_debug = 1, print the T-state and opcode on each advance, and print "halted" on halt.

Test Plan:
1. Reset, run mode, i_opcode = 0 (LDA) from T4: over 6 clocks expect T1 {pc_out, mar_load}, T2 {pc_inc}, T3 {ram_out, ir_load}, T4 {ir_out, mar_load}, T5 {ram_out, a_load}, T6 {}; o_instr_count = 1.
2. Opcode 2 (SUB): T5 {ram_out, b_load, alu_sub}, T6 {alu_out, a_load, alu_sub}. Opcode 1 (ADD) gives the same with alu_sub = 0. Bus exclusivity checked every cycle.
3. Opcode F (HLT): o_halted = 1 after the T4 edge. Run 20 more clocks: o_t_state = 6'b001000, strobes 0, count unchanged. Assert i_reset: o_halted = 0, T1.
4. Step mode, i_step held high for 10 clocks: exactly one advance with pc_out/mar_load pulsed for 1 cycle. Toggle i_step 0->1 -> T2 with pc_inc for 1 cycle.
5. Assert i_reset asynchronously mid-T5 of ADD: outputs are 0 and the ring is T1 before the next clock edge; after release the sequence restarts at T1 and the count is 0.
6. Run 256 NOP instructions (opcode 5): o_instr_count wraps 255 -> 0, and T4-T6 strobes are all 0.

Source files
------------

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer.
// A one-hot T1..T6 ring steps each instruction through fetch and execute.
// The ring state and the current opcode decode into the datapath strobes.
// The block also provides free-run and single-step control, HLT handling
// and a count of retired instructions.
module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_debug,
    input  logic [3:0] i_opcode,
    input  logic       i_step_mode,
    input  logic       i_step,
    output logic [5:0] o_t_state,
    output logic       o_pc_inc,
    output logic       o_pc_out,
    output logic       o_mar_load,
    output logic       o_ram_out,
    output logic       o_ir_load,
    output logic       o_ir_out,
    output logic       o_a_load,
    output logic       o_a_out,
    output logic       o_b_load,
    output logic       o_alu_sub,
    output logic       o_alu_out,
    output logic       o_out_load,
    output logic       o_halted,
    output logic [7:0] o_instr_count
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Bit positions of each strobe inside the packed strobe vector
    localparam int S_PC_INC   = 11;
    localparam int S_PC_OUT   = 10;
    localparam int S_MAR_LOAD = 9;
    localparam int S_RAM_OUT  = 8;
    localparam int S_IR_LOAD  = 7;
    localparam int S_IR_OUT   = 6;
    localparam int S_A_LOAD   = 5;
    localparam int S_A_OUT    = 4;
    localparam int S_B_LOAD   = 3;
    localparam int S_ALU_SUB  = 2;
    localparam int S_ALU_OUT  = 1;
    localparam int S_OUT_LOAD = 0;

    t_state_e    ring_q, ring_d;
    logic        halted_q, halted_d;
    logic [7:0]  count_q, count_d;
    logic        step_q, step_d;
    logic        adv;
    logic [11:0] strb;

    // Raw control word for one T-state; gating by adv/halt/reset happens outside
    function automatic logic [11:0] decode(input t_state_e t, input logic [3:0] op);
        logic [11:0] s;
        s = '0;
        case (t)
            T1: begin
                s[S_PC_OUT]   = 1'b1;
                s[S_MAR_LOAD] = 1'b1;
            end
            T2: begin
                s[S_PC_INC] = 1'b1;
            end
            T3: begin
                s[S_RAM_OUT] = 1'b1;
                s[S_IR_LOAD] = 1'b1;
            end
            T4: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin
                    s[S_IR_OUT]   = 1'b1;
                    s[S_MAR_LOAD] = 1'b1;
                end else if (op == OP_OUT) begin
                    s[S_A_OUT]    = 1'b1;
                    s[S_OUT_LOAD] = 1'b1;
                end
            end
            T5: begin
                if (op == OP_LDA) begin
                    s[S_RAM_OUT] = 1'b1;
                    s[S_A_LOAD]  = 1'b1;
                end else if (op == OP_ADD || op == OP_SUB) begin
                    s[S_RAM_OUT] = 1'b1;
                    s[S_B_LOAD]  = 1'b1;
                    // Subtract select goes up a state early so the ALU result settles
                    s[S_ALU_SUB] = (op == OP_SUB);
                end
            end
            T6: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    s[S_ALU_OUT] = 1'b1;
                    s[S_A_LOAD]  = 1'b1;
                    s[S_ALU_SUB] = (op == OP_SUB);
                end
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    // In step mode only the rising edge of the step request advances the ring
    assign adv = i_step_mode ? (i_step & ~step_q) : 1'b1;

    // Next-state logic for the ring, halt flag, retired count and step edge register
    always_comb begin
        ring_d   = ring_q;
        halted_d = halted_q;
        count_d  = count_q;
        step_d   = i_step;
        if (adv && !halted_q) begin
            case (ring_q)
                T1: ring_d = T2;
                T2: ring_d = T3;
                T3: ring_d = T4;
                T4: begin
                    // HLT freezes the ring in T4 instead of moving on
                    if (i_opcode == OP_HLT) begin
                        halted_d = 1'b1;
                    end else begin
                        ring_d = T5;
                    end
                end
                T5: ring_d = T6;
                T6: begin
                    ring_d  = T1;
                    count_d = count_q + 8'd1;
                end
                default: ring_d = T1;
            endcase
        end
    end

    // Sequencer state registers with asynchronous reset back to T1
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ring_q   <= T1;
            halted_q <= 1'b0;
            count_q  <= 8'd0;
            step_q   <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
            count_q  <= count_d;
            step_q   <= step_d;
        end
    end

    // Strobes fire only on an advancing cycle so a waiting step-mode cycle is idle
    assign strb = (adv && !halted_q && !i_reset) ? decode(ring_q, i_opcode) : 12'd0;

    assign o_pc_inc      = strb[S_PC_INC];
    assign o_pc_out      = strb[S_PC_OUT];
    assign o_mar_load    = strb[S_MAR_LOAD];
    assign o_ram_out     = strb[S_RAM_OUT];
    assign o_ir_load     = strb[S_IR_LOAD];
    assign o_ir_out      = strb[S_IR_OUT];
    assign o_a_load      = strb[S_A_LOAD];
    assign o_a_out       = strb[S_A_OUT];
    assign o_b_load      = strb[S_B_LOAD];
    assign o_alu_sub     = strb[S_ALU_SUB];
    assign o_alu_out     = strb[S_ALU_OUT];
    assign o_out_load    = strb[S_OUT_LOAD];
    assign o_t_state     = ring_q;
    assign o_halted      = halted_q;
    assign o_instr_count = count_q;

`ifndef SYNTHESIS
    // Simulation trace of each advance and of the halt event
    always @(posedge i_clk) begin
        if (i_debug && !i_reset && adv && !halted_q) begin
            $display("sap1: state=%b opcode=%h", ring_q, i_opcode);
            if (halted_d) begin
                $display("sap1: halted");
            end
        end
    end
`endif

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: directed sequences plus a randomized phase,
// all checked against a T-index based behavioural model of the sequencer.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       dbg;
    logic [3:0] opcode;
    logic       step_mode;
    logic       step;
    logic [5:0] t_state;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_sub, alu_out, out_load;
    logic       halted;
    logic [7:0] instr_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: T index 1..6, halt flag, count, previous step level
    int m_t;
    bit m_halted;
    int m_count;
    bit m_prev_step;

    always #5 clk = ~clk;

    sap1_controller dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_debug       (dbg),
        .i_opcode      (opcode),
        .i_step_mode   (step_mode),
        .i_step        (step),
        .o_t_state     (t_state),
        .o_pc_inc      (pc_inc),
        .o_pc_out      (pc_out),
        .o_mar_load    (mar_load),
        .o_ram_out     (ram_out),
        .o_ir_load     (ir_load),
        .o_ir_out      (ir_out),
        .o_a_load      (a_load),
        .o_a_out       (a_out),
        .o_b_load      (b_load),
        .o_alu_sub     (alu_sub),
        .o_alu_out     (alu_out),
        .o_out_load    (out_load),
        .o_halted      (halted),
        .o_instr_count (instr_count)
    );

    wire [11:0] dut_strb = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out,
                            a_load, a_out, b_load, alu_sub, alu_out, out_load};
    wire [4:0]  bus_drv  = {pc_out, ram_out, ir_out, a_out, alu_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected control word as a microcode table lookup by T index and opcode
    function automatic logic [11:0] exp_strb(input int t, input logic [3:0] op);
        bit ci = 0, co = 0, ml = 0, ro = 0, il = 0, io = 0;
        bit al = 0, ao = 0, bl = 0, su = 0, uo = 0, ol = 0;
        bit mem_op = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
        bit arith  = (op == 4'h1) || (op == 4'h2);
        case (t)
            1: begin co = 1; ml = 1; end
            2: ci = 1;
            3: begin ro = 1; il = 1; end
            4: begin
                if (mem_op) begin io = 1; ml = 1; end
                if (op == 4'hE) begin ao = 1; ol = 1; end
            end
            5: begin
                if (op == 4'h0) begin ro = 1; al = 1; end
                if (arith) begin ro = 1; bl = 1; su = (op == 4'h2); end
            end
            6: if (arith) begin uo = 1; al = 1; su = (op == 4'h2); end
            default: ;
        endcase
        return {ci, co, ml, ro, il, io, al, ao, bl, su, uo, ol};
    endfunction

    function automatic bit m_adv();
        return step_mode ? (step && !m_prev_step) : 1'b1;
    endfunction

    task automatic model_reset();
        m_t = 1;
        m_halted = 0;
        m_count = 0;
        m_prev_step = 0;
    endtask

    task automatic check_all();
        logic [11:0] e;
        logic [5:0]  one;
        one = 6'd1;
        e = (rst || m_halted || !m_adv()) ? 12'd0 : exp_strb(m_t, opcode);
        chk("t_state", 32'(t_state), 32'(one << (m_t - 1)));
        chk("strobes", 32'(dut_strb), 32'(e));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("count", 32'(instr_count), 32'(m_count));
        chk("bus_excl", 32'($countones(bus_drv) <= 1), 32'd1);
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit a;
        a = m_adv();
        m_prev_step = step;
        if (a && !m_halted) begin
            if (m_t == 4 && opcode == 4'hF) begin
                m_halted = 1;
            end else if (m_t == 6) begin
                m_t = 1;
                m_count = (m_count + 1) % 256;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    // One clock: check settled outputs, take the edge, return at the falling edge
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [8];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hE;
        ops[4] = 4'h5; ops[5] = 4'h3; ops[6] = 4'h9; ops[7] = 4'h1;

        rst = 1'b1; dbg = 1'b0; opcode = 4'h0; step_mode = 1'b0; step = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // LDA in free run with trace enabled
        dbg = 1'b1;
        opcode = 4'h0;
        repeat (6) cycle();
        dbg = 1'b0;
        chk("lda_count", 32'(instr_count), 32'd1);

        // SUB then ADD
        opcode = 4'h2;
        repeat (4) cycle();
        #1;
        chk("sub_t5_alu_sub", 32'(alu_sub), 32'd1);
        repeat (2) cycle();
        opcode = 4'h1;
        repeat (6) cycle();
        chk("add_count", 32'(instr_count), 32'd3);

        // OUT
        opcode = 4'hE;
        repeat (6) cycle();

        // HLT freezes at T4
        opcode = 4'hF;
        repeat (24) cycle();
        chk("hlt_state", 32'(t_state), 32'h08);
        chk("hlt_flag", 32'(halted), 32'd1);
        chk("hlt_count", 32'(instr_count), 32'd4);
        apply_reset();
        chk("hlt_cleared", 32'(halted), 32'd0);

        // Single step: a held request advances exactly once
        step_mode = 1'b1;
        opcode = 4'h0;
        step = 1'b1;
        repeat (10) cycle();
        chk("step_hold", 32'(t_state), 32'h02);
        step = 1'b0;
        cycle();
        step = 1'b1;
        #1;
        chk("step_pc_inc", 32'(pc_inc), 32'd1);
        repeat (3) cycle();
        chk("step_second", 32'(t_state), 32'h04);
        step = 1'b0;
        step_mode = 1'b0;

        // Asynchronous reset in the middle of T5 of ADD
        apply_reset();
        opcode = 4'h1;
        repeat (6) cycle();
        repeat (4) cycle();
        #1;
        chk("pre_async_b_load", 32'(b_load), 32'd1);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_t1", 32'(t_state), 32'h01);
        chk("async_strobes", 32'(dut_strb), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) cycle();
        chk("async_restart", 32'(instr_count), 32'd1);

        // 256 NOPs wrap the retired counter
        apply_reset();
        opcode = 4'h5;
        repeat (255 * 6) cycle();
        chk("nop_255", 32'(instr_count), 32'd255);
        repeat (6) cycle();
        chk("nop_wrap", 32'(instr_count), 32'd0);

        // Randomized opcodes, step mode and step levels
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                opcode = 4'hF;
            end else begin
                opcode = ops[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 15) == 0) begin
                step_mode = ~step_mode;
            end
            step = 1'($urandom_range(0, 1));
            if (m_halted && $urandom_range(0, 9) == 0) begin
                apply_reset();
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
